// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor cell with a registered borrow,
// LSB first, under a start/busy/done handshake.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sr;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             d;
  logic             br_n;

  // Full-subtractor cell: returns {borrow_next, difference_bit}.
  function automatic logic [1:0] fsub(input logic x, input logic y, input logic bin);
    logic dd;
    logic bb;
    dd = x ^ y ^ bin;
    bb = (~x & y) | (~(x ^ y) & bin);
    return {bb, dd};
  endfunction

  // Next-state selection.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) state_next = RUN;
        else       state_next = IDLE;
      end
      RUN: begin
        if (cnt == LAST) state_next = DONE;
        else             state_next = RUN;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Current bit of the subtraction.
  always_comb begin
    {br_n, d} = fsub(sa[0], sb[0], br);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      sa         <= '0;
      sb         <= '0;
      sr         <= '0;
      br         <= 1'b0;
      cnt        <= '0;
    end else begin
      state <= state_next;
      busy  <= (state_next != IDLE);
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sa  <= a;
            sb  <= b;
            br  <= 1'b0;
            cnt <= '0;
          end else begin
            cnt <= cnt;
          end
        end
        RUN: begin
          sa <= {1'b0, sa[WIDTH-1:1]};
          sb <= {1'b0, sb[WIDTH-1:1]};
          sr <= {d, sr[WIDTH-1:1]};
          br <= br_n;
          // Counter holds on the last bit so it never wraps mid-operation.
          if (cnt == LAST) begin
            diff       <= {d, sr[WIDTH-1:1]};
            borrow_out <= br_n;
            done       <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE:    cnt <= cnt;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed vector table at WIDTH=8,
// multi-cycle corner sequences, and an exhaustive sweep at WIDTH=4.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, busy8, done8, borrow8;
  logic [7:0] a8, b8, diff8;
  logic       start4, busy4, done4, borrow4;
  logic [3:0] a4, b4, diff4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow_out(borrow8)
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .diff(diff4), .borrow_out(borrow4)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_diff;
    logic       exp_borrow;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Run one WIDTH=8 operation over a fixed window; optionally disturb inputs mid-RUN.
  task automatic op8(input logic [7:0] av, input logic [7:0] bv, input bit perturb,
                     output int lat, output int busyc, output int donec,
                     output logic [7:0] d, output logic br);
    lat = -1; busyc = 0; donec = 0; d = 8'hxx; br = 1'bx;
    @(negedge clk);
    a8 = av; b8 = bv; start8 = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (busy8) busyc++;
      if (done8) begin
        donec++;
        lat = k;
        d = diff8;
        br = borrow8;
      end
      if (k == 0) start8 = 1'b0;
      if (perturb && k >= 1 && k <= 6) begin
        a8 = 8'($urandom);
        b8 = 8'($urandom);
      end
      if (perturb && k == 3) begin
        a8 = 8'h00; b8 = 8'hFF; start8 = 1'b1;
      end
      if (perturb && k == 4) start8 = 1'b0;
    end
  endtask

  task automatic op4(input logic [3:0] av, input logic [3:0] bv,
                     output int lat, output logic [3:0] d, output logic br);
    lat = -1; d = 4'hx; br = 1'bx;
    @(negedge clk);
    a4 = av; b4 = bv; start4 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) start4 = 1'b0;
      if (done4) begin
        lat = k;
        d = diff4;
        br = borrow4;
      end
    end
  endtask

  initial begin
    int lat, busyc, donec, t1, t2, ndone;
    logic [7:0] d, dd1, dd2;
    logic br, bb1, bb2, hold_ok;
    logic [3:0] d4, e4;

    vecs[0] = '{8'h5A, 8'h23, 8'h37, 1'b0};
    vecs[1] = '{8'h10, 8'h20, 8'hF0, 1'b1};
    vecs[2] = '{8'h00, 8'h01, 8'hFF, 1'b1};
    vecs[3] = '{8'hAA, 8'hAA, 8'h00, 1'b0};

    rst = 1'b1; start8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    start4 = 1'b0; a4 = 4'h0; b4 = 4'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_busy", 32'(busy8), 32'd0);
    check("reset_done", 32'(done8), 32'd0);
    check("reset_diff", 32'(diff8), 32'd0);
    check("reset_borrow", 32'(borrow8), 32'd0);
    check("reset_w4", {27'd0, busy4, done4, borrow4, diff4 == 4'h0}, 32'd1);

    foreach (vecs[i]) begin
      op8(vecs[i].a, vecs[i].b, 1'b0, lat, busyc, donec, d, br);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd8);
      check($sformatf("vec%0d_diff", i), 32'(d), 32'(vecs[i].exp_diff));
      check($sformatf("vec%0d_borrow", i), 32'(br), 32'(vecs[i].exp_borrow));
      check($sformatf("vec%0d_busy_cycles", i), 32'(busyc), 32'd9);
      check($sformatf("vec%0d_done_count", i), 32'(donec), 32'd1);
    end

    // Start pulse and operand churn during RUN must be ignored.
    op8(8'h80, 8'h01, 1'b1, lat, busyc, donec, d, br);
    check("busyprot_diff", 32'(d), 32'h7F);
    check("busyprot_borrow", 32'(br), 32'd0);
    check("busyprot_done_count", 32'(donec), 32'd1);
    check("busyprot_busy_cycles", 32'(busyc), 32'd9);

    // Reset during RUN abandons the operation.
    op8(8'h5A, 8'h23, 1'b0, lat, busyc, donec, d, br);
    check("prior_diff", 32'(diff8), 32'h37);
    @(negedge clk);
    a8 = 8'h33; b8 = 8'h11; start8 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) start8 = 1'b0;
      if (k == 3) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", 32'(busy8), 32'd0);
    check("midrst_diff", 32'(diff8), 32'd0);
    check("midrst_done", 32'(done8), 32'd0);
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done8) ndone++;
    end
    check("midrst_no_done", 32'(ndone), 32'd0);
    op8(8'h33, 8'h11, 1'b0, lat, busyc, donec, d, br);
    check("postrst_diff", 32'(d), 32'h22);
    check("postrst_latency", 32'(lat), 32'd8);

    // Back-to-back with start held high.
    t1 = -1; t2 = -1; ndone = 0; hold_ok = 1'b1;
    dd1 = 8'h00; dd2 = 8'h00; bb1 = 1'b0; bb2 = 1'b0;
    @(negedge clk);
    a8 = 8'h05; b8 = 8'h03; start8 = 1'b1;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      if (k == 0) begin a8 = 8'h03; b8 = 8'h05; end
      if (k == 10) start8 = 1'b0;
      if (done8) begin
        ndone++;
        if (ndone == 1) begin t1 = k; dd1 = diff8; bb1 = borrow8; end
        if (ndone == 2) begin t2 = k; dd2 = diff8; bb2 = borrow8; end
      end else if (ndone == 1 && diff8 !== 8'h02) begin
        hold_ok = 1'b0;
      end
    end
    check("b2b_done_count", 32'(ndone), 32'd2);
    check("b2b_spacing", 32'(t2 - t1), 32'd10);
    check("b2b_first_diff", 32'(dd1), 32'h02);
    check("b2b_first_borrow", 32'(bb1), 32'd0);
    check("b2b_second_diff", 32'(dd2), 32'hFE);
    check("b2b_second_borrow", 32'(bb2), 32'd1);
    check("b2b_diff_hold", 32'(hold_ok), 32'd1);

    // Exhaustive sweep at WIDTH=4.
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        op4(4'(i), 4'(j), lat, d4, br);
        e4 = 4'(i - j);
        check($sformatf("w4_lat_%0d_%0d", i, j), 32'(lat), 32'd4);
        check($sformatf("w4_diff_%0d_%0d", i, j), 32'(d4), 32'(e4));
        check($sformatf("w4_borrow_%0d_%0d", i, j), 32'(br), 32'(i < j));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial unsigned subtractor. Computes `a - b` one bit per clock, LSB first, using a single full-subtractor cell and a registered borrow. It is the subtract-direction counterpart of the combinational full-adder cell in the arithmetic library. It serves area-constrained datapaths that can trade latency for a single 1-bit cell, and uses a start/done handshake toward the controlling FSM.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range ≥ 2.

Ports (one clock; reset is synchronous and active-high):
- `clk`  input  1  system clock; all state updates on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `start`  input  1  request; sampled only in IDLE.
- `a`  input  WIDTH  minuend; captured on the accepting edge only.
- `b`  input  WIDTH  subtrahend; captured on the accepting edge only.
- `busy`  output  1  high in RUN and DONE states.
- `done`  output  1  one-cycle pulse when `diff`/`borrow_out` update.
- `diff`  output  WIDTH  `(a - b) mod 2^WIDTH`.
- `borrow_out`  output  1  final borrow; 1 exactly when `a < b` (unsigned).

## Operation
- **FSM states:** IDLE, RUN, DONE.
- **IDLE:**
  - On `start` = 1, load shift registers `sa` ← `a`, `sb` ← `b`, clear borrow flop `br`, set bit counter `cnt` ← 0, then go to RUN.
  - On `start` = 0, stay in IDLE.
- **RUN:** each cycle processes bit 0 of `sa`/`sb`:
  - Difference bit `d = sa[0] ^ sb[0] ^ br`.
  - Next borrow `br_n = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br)`.
  - `sa`, `sb` shift right by 1. `d` shifts into the MSB of internal result register `sr` (also shifted right). `br` ← `br_n`. `cnt` ← `cnt + 1`.
  - On the cycle where `cnt == WIDTH-1`:
    - `diff` ← final `sr` contents, including this bit.
    - `borrow_out` ← `br_n`.
    - `done` ← 1.
    - Go to DONE.
- **DONE:**
  - `done` returns to 0 on the next edge.
  - Next state is IDLE.
  - `start` is ignored in this state.
- **Counter:** `cnt` width is `$clog2(WIDTH)`; it does not wrap within an operation.
- **Arithmetic:** unsigned, modulo 2^WIDTH. A signed interpretation of `diff` is valid two's-complement when no signed overflow occurs; signed overflow is not flagged.
- **Output registers:**
  - `diff` and `borrow_out` are registers that change only on the DONE-entry edge or on reset.
  - They hold the previous result through IDLE and through the whole RUN of the next operation.
- **Busy handling:** `start` pulses while `busy` = 1 are dropped, not queued. Changes on `a`/`b` after the accepting edge have no effect.
- **Reset:** `rst` = 1 at any edge forces:
  - state IDLE;
  - `busy`, `done`, `diff`, `borrow_out`, `sa`, `sb`, `sr`, `br`, `cnt` all 0.
  - Reset has priority over `start`.
  - An operation in progress is abandoned, with no `done` pulse.

## Timing
- **Reset values:** `busy` = 0, `done` = 0, `diff` = 0, `borrow_out` = 0.
- **Edge-by-edge sequence:**
  - Edge E0: `start` accepted in IDLE; `busy` = 1 from E0.
  - Edges E1..E(WIDTH): one bit each.
  - At E(WIDTH): `diff`, `borrow_out` and `done` = 1 update together.
  - At E(WIDTH+1): `done` = 0, `busy` = 0, state IDLE.
  - Earliest next accept: E(WIDTH+2), because `start` is sampled in IDLE. Throughput is one operation per WIDTH+2 cycles.
- **Latency:** `start` accept to `done` is WIDTH cycles (8 at the default).
- **Back-to-back:** `start` held high continuously starts a new operation every WIDTH+2 cycles, with fresh `a`/`b` sampled at each accept.
- **Combinational paths:** none from inputs to outputs.

## Test plan
- Reset then basic subtract: `rst` for 2 cycles, then check all outputs are 0. Then `a` = 0x5A, `b` = 0x23, 1-cycle `start` → `done` exactly 8 cycles after accept, `diff` = 0x37, `borrow_out` = 0, `busy` high for 9 cycles.
- Borrow cases:
  - 0x10 − 0x20 → `diff` = 0xF0, `borrow_out` = 1.
  - 0x00 − 0x01 → `diff` = 0xFF, `borrow_out` = 1.
  - 0xAA − 0xAA → `diff` = 0x00, `borrow_out` = 0.
- Busy protection: accept 0x80 − 0x01, then pulse `start` with `a` = 0x00, `b` = 0xFF mid-RUN and change `a`/`b` every cycle → single `done`, `diff` = 0x7F, `borrow_out` = 0, no second operation.
- Reset mid-operation:
  - Accept 0x33 − 0x11 after a prior result of 0x37. Assert `rst` at cycle 4 of RUN → next edge `busy` = 0, `diff` = 0, no `done`.
  - After reset, accept 0x33 − 0x11 → `diff` = 0x22.
- Back-to-back: `start` held high with operands 0x05 − 0x03, then 0x03 − 0x05 → `done` pulses 10 cycles apart, results 0x02/0 then 0xFE/1. `diff` holds 0x02 until the second `done`.
- Exhaustive at `WIDTH` = 4: all 256 (`a`, `b`) pairs → `diff` == (`a` − `b`) mod 16 and `borrow_out` == (`a` < `b`) each time, with `done` latency 4.
